// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: parses the SPI byte stream (header, length, payload) into one-byte I2C commands.
// Latency: every output is registered; a byte or response at edge N is acted on by edge N+1.
// Backpressure: cmd_valid_o is held until cmd_ready_i, with one command outstanding; there is no backpressure on the SPI side.
// Ports: clk_i/reset_i (async, active-high); frame_active_i, rx_data_i, rx_valid_i from spi_slave; tx_data_o to spi_slave;
//        cmd_* command channel to the I2C master; rsp_* completion from it; busy_o/err_o/overflow_o status.
module spi_frame_decoder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             frame_active_i,
  input  logic [WIDTH-1:0] rx_data_i,
  input  logic             rx_valid_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [6:0]       cmd_addr_o,
  output logic             cmd_rw_o,
  output logic [WIDTH-1:0] cmd_data_o,
  output logic             cmd_first_o,
  output logic             cmd_last_o,
  output logic             cmd_abort_o,
  input  logic             rsp_valid_i,
  input  logic [WIDTH-1:0] rsp_data_i,
  input  logic             rsp_nack_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             overflow_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [4:0]       count_q, count_d;    // frame length, 1..16
  logic [4:0]       rx_cnt_q, rx_cnt_d;  // payload/dummy bytes seen
  logic [4:0]       issued_q, issued_d;  // commands presented
  logic [4:0]       done_q, done_d;      // responses received
  logic             pend_q, pend_d;      // accepted command awaiting its response
  logic             last_acc_q, last_acc_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [6:0]       cmd_addr_q, cmd_addr_d;
  logic             cmd_rw_q, cmd_rw_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic             cmd_first_q, cmd_first_d;
  logic             cmd_last_q, cmd_last_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] tx_q, tx_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       fcnt_q, fcnt_d;

  logic             push, pop, flush, hs, rsp, issue;
  logic [WIDTH-1:0] push_dat;
  logic [7:0]       status;

  assign status = {busy_q, err_q, ovf_q, 1'b0, fcnt_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    count_d     = count_q;
    rx_cnt_d    = rx_cnt_q;
    issued_d    = issued_q;
    done_d      = done_q;
    pend_d      = pend_q;
    last_acc_d  = last_acc_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_data_d  = cmd_data_q;
    cmd_first_d = cmd_first_q;
    cmd_last_d  = cmd_last_q;
    abort_d     = 1'b0;
    err_d       = err_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    issue       = 1'b0;
    push_dat    = rx_data_i;
    hs          = cmd_valid_q & cmd_ready_i;
    rsp         = rsp_valid_i & pend_q;

    // A write byte stays at the FIFO head until the master takes it, so a
    // stalled master leaves the full FIFO depth available for payload.
    if (hs) begin
      cmd_valid_d = 1'b0;
      pend_d      = 1'b1;
      last_acc_d  = cmd_last_q;
      pop         = (state_q == S_WR);
    end
    if (rsp) begin
      pend_d = 1'b0;
      done_d = done_q + 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_active_i && rx_valid_i) begin
          addr_d  = rx_data_i[7:1];
          rw_d    = rx_data_i[0];
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          flush   = 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (!frame_active_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          count_d    = {1'b0, rx_data_i[3:0]} + 5'd1;
          rx_cnt_d   = 5'd0;
          issued_d   = 5'd0;
          done_d     = 5'd0;
          last_acc_d = 1'b0;
          state_d    = rw_q ? S_RD : S_WR;
        end
      end
      S_WR, S_RD: begin
        if (!frame_active_i) begin
          // No abort once the STOP-carrying byte has been accepted.
          if ((cmd_valid_q || pend_q || issued_q != count_q) && !last_acc_q && !(hs && cmd_last_q))
            abort_d = 1'b1;
          cmd_valid_d = 1'b0;
          state_d     = S_DRAIN;
        end else if (rsp && rsp_nack_i) begin
          err_d   = 1'b1;
          abort_d = !last_acc_q;
          flush   = 1'b1;
          state_d = S_DONE;
        end else if (state_q == S_WR) begin
          if (rx_valid_i && rx_cnt_q != count_q) begin
            rx_cnt_d = rx_cnt_q + 5'd1;
            if (fcnt_q == FULL_CNT && !pop) begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          issue = (fcnt_q != 4'd0);
          if (rsp && done_d == count_q) begin
            flush   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          if (rx_valid_i && rx_cnt_q != count_q) begin
            rx_cnt_d = rx_cnt_q + 5'd1;
            if (fcnt_q != 4'd0) pop = 1'b1;
            else                err_d = 1'b1;
          end
          if (rsp) begin
            push_dat = rsp_data_i;
            if (fcnt_q == FULL_CNT && !pop) begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          issue = 1'b1;
          if (done_d == count_q && rx_cnt_d == count_q) begin
            flush   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        cmd_valid_d = 1'b0;
        if (!pend_q || rsp) begin
          flush   = 1'b1;
          state_d = frame_active_i ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!frame_active_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue && !cmd_valid_q && !pend_q && issued_q != count_q) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = addr_q;
      cmd_rw_d    = rw_q;
      cmd_data_d  = rw_q ? '0 : mem_q[rd_ptr_q];
      cmd_first_d = (issued_q == 5'd0);
      cmd_last_d  = (issued_q == count_q - 5'd1);
      issued_d    = issued_q + 5'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fcnt_d   = 4'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      fcnt_d = fcnt_q + {3'b0, push} - {3'b0, pop};
    end
    busy_d = (state_d != S_IDLE);
    // Once a response has arrived, an empty FIFO in RD means the host is
    // reading faster than the I2C side delivers, so 0xFF marks the gap.
    if (state_q == S_RD && fcnt_q != 4'd0) tx_d = mem_q[rd_ptr_q];
    else if (state_q == S_RD && done_q != 5'd0) tx_d = 8'hFF;
    else tx_d = status;
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      count_q     <= '0;
      rx_cnt_q    <= '0;
      issued_q    <= '0;
      done_q      <= '0;
      pend_q      <= 1'b0;
      last_acc_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_rw_q    <= 1'b0;
      cmd_data_q  <= '0;
      cmd_first_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tx_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      count_q     <= count_d;
      rx_cnt_q    <= rx_cnt_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      last_acc_q  <= last_acc_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_data_q  <= cmd_data_d;
      cmd_first_q <= cmd_first_d;
      cmd_last_q  <= cmd_last_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      tx_q        <= tx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign tx_data_o   = tx_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_rw_o    = cmd_rw_q;
  assign cmd_data_o  = cmd_data_q;
  assign cmd_first_o = cmd_first_q;
  assign cmd_last_o  = cmd_last_q;
  assign cmd_abort_o = abort_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: directed + randomized frames against a frame-level model of the decoder.
// Latency: the I2C responder answers 1..3 cycles after each accepted command (or on release when held).
// Backpressure: cmd_ready_i is driven by the bench; held low to stall the command channel.
module tb_spi_frame_decoder;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       frame_active_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       cmd_valid_o;
  logic       cmd_ready_i;
  logic [6:0] cmd_addr_o;
  logic       cmd_rw_o;
  logic [7:0] cmd_data_o;
  logic       cmd_first_o;
  logic       cmd_last_o;
  logic       cmd_abort_o;
  logic       rsp_valid_i;
  logic [7:0] rsp_data_i;
  logic       rsp_nack_i;
  logic       busy_o;
  logic       err_o;
  logic       overflow_o;

  spi_frame_decoder #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_active_i(frame_active_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .tx_data_o(tx_data_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o),
    .cmd_rw_o(cmd_rw_o), .cmd_data_o(cmd_data_o), .cmd_first_o(cmd_first_o),
    .cmd_last_o(cmd_last_o), .cmd_abort_o(cmd_abort_o), .rsp_valid_i(rsp_valid_i),
    .rsp_data_i(rsp_data_i), .rsp_nack_i(rsp_nack_i), .busy_o(busy_o),
    .err_o(err_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  int         abort_cnt = 0;
  int         nack_idx = -1;
  bit         rsp_hold = 1'b0;
  bit         rsp_drop = 1'b0;
  logic [17:0] log_q[$];   // {addr, rw, data, first, last} per accepted command
  logic [7:0]  pay_q[$];   // payload bytes of the current write frame
  logic [7:0]  rd_q[$];    // bytes the I2C slave returns, consumed by the responder
  logic [7:0]  exp_q[$];   // copy of rd_q for checking tx_data_o

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // I2C master model: logs each transfer and answers with a single-cycle response.
  initial begin
    int idx;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 8'h00;
    rsp_nack_i  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cmd_valid_o && cmd_ready_i) begin
        log_q.push_back({cmd_addr_o, cmd_rw_o, cmd_data_o, cmd_first_o, cmd_last_o});
        idx = log_q.size() - 1;
        @(posedge clk_i);
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
        while (rsp_hold) @(negedge clk_i);
        if (!rsp_drop) begin
          rsp_valid_i = 1'b1;
          rsp_nack_i  = (idx == nack_idx);
          rsp_data_i  = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          @(negedge clk_i);
          rsp_valid_i = 1'b0;
          rsp_nack_i  = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (cmd_abort_o) abort_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] hdr, input logic [7:0] lenb);
    log_q.delete();
    @(negedge clk_i);
    frame_active_i = 1'b1;
    send_byte(hdr);
    send_byte(lenb);
  endtask

  task automatic end_frame();
    @(negedge clk_i);
    frame_active_i = 1'b0;
    idle(4);
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 500) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, 32'(log_q.size()), 32'(n));
  endtask

  // Expected command i of a frame: header address/rw, payload byte (0 for reads),
  // first flag on index 0, last flag on index count-1.
  task automatic check_cmds(input logic [6:0] a, input logic rw, input int cnt, input int n);
    logic [31:0] obs, exp;
    for (int i = 0; i < n; i++) begin
      obs = (i < log_q.size()) ? 32'(log_q[i]) : 32'hDEAD_BEEF;
      exp = 32'({a, rw, (rw ? 8'h00 : pay_q[i]), (i == 0), (i == cnt - 1)});
      chk($sformatf("cmd%0d", i), obs, exp);
    end
  endtask

  initial begin
    logic [6:0] a;
    int         cnt;
    int         a0;

    reset_i        = 1'b1;
    frame_active_i = 1'b0;
    rx_data_i      = 8'h00;
    rx_valid_i     = 1'b0;
    cmd_ready_i    = 1'b1;
    idle(2);
    chk("rst_tx", 32'(tx_data_o), 32'h00);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err_ovf_abort", 32'({err_o, overflow_o, cmd_abort_o}), 32'h0);
    reset_i = 1'b0;
    idle(2);

    // Directed write: addr 0x50, two bytes; command follows payload byte by one edge.
    pay_q = '{8'h12, 8'h34};
    start_frame(8'hA0, 8'h01);
    send_byte(8'h12);
    chk("wr_lat_n", 32'(cmd_valid_o), 32'h0);
    @(negedge clk_i);
    chk("wr_lat_n1", 32'(cmd_valid_o), 32'h1);
    send_byte(8'h34);
    wait_log(2, "wr_cmd_count");
    idle(10);
    check_cmds(7'h50, 1'b0, 2, 2);
    chk("wr_err", 32'(err_o), 32'h0);
    chk("wr_done_status", 32'(tx_data_o), 32'h80);
    end_frame();
    chk("wr_idle_busy", 32'(busy_o), 32'h0);
    chk("wr_idle_status", 32'(tx_data_o), 32'h00);

    // Random write frames with two surplus bytes beyond the count.
    for (int r = 0; r < 3; r++) begin
      a   = 7'($urandom);
      cnt = $urandom_range(1, 8);
      pay_q.delete();
      for (int i = 0; i < cnt + 2; i++) pay_q.push_back(8'($urandom));
      start_frame({a, 1'b0}, {4'($urandom), 4'(cnt - 1)});
      for (int i = 0; i < cnt + 2; i++) send_byte(pay_q[i]);
      wait_log(cnt, "rwr_cmd_count");
      idle(12);
      chk("rwr_no_extra", 32'(log_q.size()), 32'(cnt));
      check_cmds(a, 1'b0, cnt, cnt);
      chk("rwr_err_ovf", 32'({err_o, overflow_o}), 32'h0);
      chk("rwr_done_status", 32'(tx_data_o), 32'h80);
      end_frame();
    end

    // Directed read: three bytes returned and popped by dummy bytes.
    rd_q  = '{8'h5A, 8'h6B, 8'h7C};
    exp_q = rd_q;
    start_frame(8'hA1, 8'h02);
    @(negedge clk_i);
    chk("rd_status_pre", 32'(tx_data_o), 32'h80);
    idle(40);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_tx%0d", i), 32'(tx_data_o), 32'(exp_q[i]));
      send_byte(8'h00);
      idle(3);
    end
    chk("rd_done_status", 32'(tx_data_o), 32'h80);
    check_cmds(7'h50, 1'b1, 3, 3);
    end_frame();
    chk("rd_idle_status", 32'(tx_data_o), 32'h00);

    // Random read frames.
    for (int r = 0; r < 2; r++) begin
      a   = 7'($urandom);
      cnt = $urandom_range(1, 8);
      rd_q.delete();
      for (int i = 0; i < cnt; i++) rd_q.push_back(8'($urandom));
      exp_q = rd_q;
      start_frame({a, 1'b1}, {4'h0, 4'(cnt - 1)});
      idle(20 + 10 * cnt);
      for (int i = 0; i < cnt; i++) begin
        chk($sformatf("rrd_tx%0d", i), 32'(tx_data_o), 32'(exp_q[i]));
        send_byte(8'($urandom));
        idle(3);
      end
      check_cmds(a, 1'b1, cnt, cnt);
      chk("rrd_err", 32'(err_o), 32'h0);
      end_frame();
    end

    // NACK on the second of four write bytes.
    a        = 7'($urandom);
    nack_idx = 1;
    a0       = abort_cnt;
    pay_q.delete();
    for (int i = 0; i < 4; i++) pay_q.push_back(8'($urandom));
    start_frame({a, 1'b0}, 8'h03);
    for (int i = 0; i < 4; i++) send_byte(pay_q[i]);
    idle(30);
    chk("nack_cmd_count", 32'(log_q.size()), 32'd2);
    check_cmds(a, 1'b0, 4, 2);
    chk("nack_abort", 32'(abort_cnt - a0), 32'd1);
    chk("nack_err", 32'(err_o), 32'h1);
    chk("nack_status", 32'(tx_data_o), 32'hC0);
    end_frame();
    nack_idx = -1;

    // Overflow: master stalled, 10-byte write into an 8-deep FIFO.
    cmd_ready_i = 1'b0;
    a0 = abort_cnt;
    start_frame({7'($urandom), 1'b0}, 8'h09);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    idle(4);
    chk("ovf_flags", 32'({overflow_o, err_o}), 32'h3);
    chk("ovf_status", 32'(tx_data_o), 32'hE8);
    chk("ovf_cmd_held", 32'(cmd_valid_o), 32'h1);
    end_frame();
    chk("ovf_abort", 32'(abort_cnt - a0), 32'd1);
    chk("ovf_idle_status", 32'(tx_data_o), 32'h60);
    cmd_ready_i = 1'b1;

    // Frame dropped after the first of three bytes with its command outstanding.
    rsp_hold = 1'b1;
    a0 = abort_cnt;
    start_frame({7'($urandom), 1'b0}, 8'h02);
    send_byte(8'($urandom));
    wait_log(1, "abt_first_cmd");
    idle(2);
    frame_active_i = 1'b0;
    idle(4);
    chk("abt_abort", 32'(abort_cnt - a0), 32'd1);
    chk("abt_drain_busy", 32'(busy_o), 32'h1);
    rsp_hold = 1'b0;
    idle(10);
    chk("abt_idle_busy", 32'(busy_o), 32'h0);
    chk("abt_idle_status", 32'(tx_data_o), 32'h00);
    chk("abt_cmd_count", 32'(log_q.size()), 32'd1);

    // Reset in the middle of a read with a command outstanding.
    rsp_hold = 1'b1;
    rsp_drop = 1'b1;
    start_frame({7'($urandom), 1'b1}, 8'h03);
    wait_log(1, "rst_rd_first_cmd");
    idle(2);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_o), 32'h0);
    chk("rst_mid_tx", 32'(tx_data_o), 32'h00);
    chk("rst_mid_cmd", 32'({cmd_valid_o, cmd_abort_o, err_o, overflow_o}), 32'h0);
    frame_active_i = 1'b0;
    @(negedge clk_i);
    reset_i  = 1'b0;
    rsp_hold = 1'b0;
    idle(6);
    rsp_drop = 1'b0;
    a = 7'($urandom);
    pay_q.delete();
    for (int i = 0; i < 2; i++) pay_q.push_back(8'($urandom));
    start_frame({a, 1'b0}, 8'h01);
    for (int i = 0; i < 2; i++) send_byte(pay_q[i]);
    wait_log(2, "post_rst_cmd_count");
    idle(10);
    check_cmds(a, 1'b0, 2, 2);
    chk("post_rst_status", 32'(tx_data_o), 32'h80);
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
